// File: rtl/hist_pkg.sv
// Shared types and constants for the histogram statistics block.
package hist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  localparam int unsigned REPORT_BYTES = 8;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned TOTAL_W      = 24;
  localparam int unsigned NZ_W         = 16;
  localparam int unsigned PEAK_W       = 16;
  localparam int unsigned REPORT_W     = REPORT_BYTES * BYTE_W;
  localparam int unsigned BIDX_W       = $clog2(REPORT_BYTES);

  // Report payload, most significant field is transmitted first.
  typedef struct packed {
    logic [PEAK_W-1:0]  peak_idx;
    logic [BYTE_W-1:0]  peak_cnt;
    logic [TOTAL_W-1:0] total;
    logic [NZ_W-1:0]    nonzero;
  } report_t;

endpackage : hist_pkg

// File: rtl/hist_stats_ser.sv
// Eight-byte report serializer with a valid/ready output handshake.
module hist_stats_ser
  import hist_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  report_t           report_i,
  input  logic              out_ready_i,
  output logic [BYTE_W-1:0] out_data_o,
  output logic              out_valid_o,
  output logic              out_last_o
);

  logic [REPORT_W-1:0] rep_bits;
  logic [REPORT_W-1:0] sh_q, sh_d;
  logic [BIDX_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;

  assign rep_bits = report_i;

  // Load a snapshot or advance one byte per accepted transfer.
  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load_i) begin
      data_d  = rep_bits[REPORT_W-1 -: BYTE_W];
      sh_d    = {rep_bits[REPORT_W-BYTE_W-1:0], BYTE_W'(0)};
      cnt_d   = '0;
      valid_d = 1'b1;
      last_d  = 1'b0;
    end else if (valid_q && out_ready_i) begin
      if (last_q) begin
        data_d  = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        data_d = sh_q[REPORT_W-1 -: BYTE_W];
        sh_d   = {sh_q[REPORT_W-BYTE_W-1:0], BYTE_W'(0)};
        cnt_d  = cnt_q + BIDX_W'(1);
        last_d = (cnt_q == BIDX_W'(REPORT_BYTES - 2));
      end
    end
  end

  // Serializer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;

endmodule : hist_stats_ser

// File: rtl/hist_stats.sv
// Per-frame histogram statistics: peak bin, total count, nonzero bins.
module hist_stats
  import hist_pkg::*;
#(
  parameter int unsigned IDX_W = 15,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] bin_data,
  input  logic             bin_valid,
  input  logic             bin_last,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [1:0]       err
);

  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               full_q, full_d;
  logic [IDX_W-1:0]   peak_idx_q, peak_idx_d;
  logic [CNT_W-1:0]   peak_cnt_q, peak_cnt_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [NZ_W-1:0]    nz_q, nz_d;
  logic [1:0]         err_q, err_d;
  logic               load_c;
  logic               ser_done_c;
  report_t            report_c;

  assign ser_done_c = out_valid & out_ready & out_last;

  // Next-state and statistics update for each accepted beat.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    full_d     = full_q;
    peak_idx_d = peak_idx_q;
    peak_cnt_d = peak_cnt_q;
    total_d    = total_q;
    nz_d       = nz_q;
    err_d      = err_q;
    load_c     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bin_valid) begin
          peak_idx_d = '0;
          peak_cnt_d = bin_data;
          total_d    = TOTAL_W'(bin_data);
          nz_d       = NZ_W'(bin_data != '0);
          idx_d      = IDX_W'(1);
          full_d     = 1'b0;
          if (bin_last) begin
            state_d = ST_REPORT;
            load_c  = 1'b1;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (bin_valid) begin
          total_d = total_q + TOTAL_W'(bin_data);
          nz_d    = nz_q + NZ_W'(bin_data != '0);
          if (full_q) begin
            // Index space exhausted: beat only feeds the sums.
            err_d[1] = 1'b1;
          end else begin
            if (bin_data > peak_cnt_q) begin
              peak_idx_d = idx_q;
              peak_cnt_d = bin_data;
            end
            if (idx_q == IDX_MAX) begin
              full_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          if (bin_last) begin
            state_d = ST_REPORT;
            load_c  = 1'b1;
          end
        end
      end
      ST_REPORT: begin
        if (bin_valid) begin
          err_d[0] = 1'b1;
        end
        if (ser_done_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d != ST_REPORT);
  end

  // Snapshot includes the final beat of the frame.
  always_comb begin
    report_c          = '0;
    report_c.peak_idx = PEAK_W'(peak_idx_d);
    report_c.peak_cnt = BYTE_W'(peak_cnt_d);
    report_c.total    = total_d;
    report_c.nonzero  = nz_d;
  end

  // Control and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b1;
      idx_q      <= '0;
      full_q     <= 1'b0;
      peak_idx_q <= '0;
      peak_cnt_q <= '0;
      total_q    <= '0;
      nz_q       <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      idx_q      <= idx_d;
      full_q     <= full_d;
      peak_idx_q <= peak_idx_d;
      peak_cnt_q <= peak_cnt_d;
      total_q    <= total_d;
      nz_q       <= nz_d;
      err_q      <= err_d;
    end
  end

  hist_stats_ser u_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_c),
    .report_i    (report_c),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_last_o  (out_last)
  );

  assign in_ready = in_ready_q;
  assign err      = err_q;

endmodule : hist_stats

// File: tb/tb_hist_stats.sv
// Randomized and directed checks of hist_stats against a frame-level model.
module tb_hist_stats;

  localparam int unsigned IDX_W = 9;
  localparam int BOUND = 2000;

  logic       clk;
  logic       rst_n;
  logic [7:0] bin_data;
  logic       bin_valid;
  logic       bin_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [1:0] err;

  int checks = 0;
  int errors = 0;
  int rmode  = 0;  // 0: ready high, 1: random, 2: ready low

  logic [7:0] exp_q[$];
  logic [7:0] frame_q[$];
  logic [7:0] got_q[$];
  logic [1:0] merr;

  hist_stats #(.IDX_W(IDX_W), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bin_data  (bin_data),
    .bin_valid (bin_valid),
    .bin_last  (bin_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Report of a whole frame, straight from the rules.
  function automatic logic [63:0] model_report(input logic [7:0] f[$]);
    int unsigned tot = 0, nz = 0, pi = 0, pc = 0;
    for (int i = 0; i < f.size(); i++) begin
      tot += f[i];
      if (f[i] != 0) nz++;
      if (i < (1 << IDX_W) && f[i] > pc) begin
        pc = f[i];
        pi = i;
      end
    end
    return {16'(pi), 8'(pc), 24'(tot), 16'(nz)};
  endfunction

  // Compare outputs with the model, then advance the model to the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      exp_q.delete();
      frame_q.delete();
      merr = 2'b00;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() == 0));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("out_data", 64'(out_data), 64'(exp_q[0]));
        chk("out_last", 64'(out_last), 64'(exp_q.size() == 1));
      end
      chk("err", 64'(err), 64'(merr));
      if (out_valid && out_ready && exp_q.size() != 0) begin
        got_q.push_back(out_data);
        void'(exp_q.pop_front());
      end
      if (bin_valid) begin
        if (in_ready) begin
          frame_q.push_back(bin_data);
          if (frame_q.size() > (1 << IDX_W)) merr[1] = 1'b1;
          if (bin_last) begin
            logic [63:0] r;
            r = model_report(frame_q);
            for (int i = 7; i >= 0; i--) exp_q.push_back(r[i*8 +: 8]);
            frame_q.delete();
          end
        end else begin
          merr[0] = 1'b1;
        end
      end
    end
  end

  // Output-side backpressure.
  always @(posedge clk) begin
    #1;
    case (rmode)
      1:       out_ready = ($urandom_range(0, 3) != 0);
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  task automatic send_beat(input logic [7:0] d, input logic last);
    int n = 0;
    while (!in_ready && n < BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= BOUND) chk("in_ready_timeout", 64'd0, 64'd1);
    bin_valid = 1'b1;
    bin_data  = d;
    bin_last  = last;
    @(posedge clk); #1;
    bin_valid = 1'b0;
    bin_last  = 1'b0;
    bin_data  = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gaps);
    for (int i = 0; i < f.size(); i++) begin
      send_beat(f[i], i == f.size() - 1);
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= BOUND) chk("report_timeout", 64'd0, 64'd1);
  endtask

  task automatic chk_got(input string nm, input logic [63:0] exp);
    logic [63:0] v = '0;
    chk({nm, "_count"}, 64'(got_q.size()), 64'd8);
    for (int i = 0; i < got_q.size() && i < 8; i++) v = {v[55:0], got_q[i]};
    chk(nm, v, exp);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] f[$];
    rst_n = 1'b0; bin_valid = 1'b0; bin_last = 1'b0; bin_data = 8'h00;
    out_ready = 1'b1; merr = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    f = '{8'd3, 8'd7, 8'd7, 8'd0};
    chk("model_pin_a", model_report(f), 64'h0001_07_000011_0003);
    f = '{8'd0, 8'd0, 8'd0};
    chk("model_pin_zero", model_report(f), 64'h0000_00_000000_0000);

    // Basic frame with a tie for the peak.
    got_q.delete();
    f = '{8'd3, 8'd7, 8'd7, 8'd0};
    send_frame(f, 1'b0);
    wait_idle();
    chk_got("frame_3770", 64'h0001_07_000011_0003);

    // Single beat with valid and last together in idle.
    got_q.delete();
    f = '{8'd5};
    send_frame(f, 1'b0);
    wait_idle();
    chk_got("single_beat", 64'h0000_05_000005_0001);

    // Beat offered during a report is dropped.
    got_q.delete();
    f = '{8'd9, 8'd4};
    send_frame(f, 1'b0);
    bin_valid = 1'b1; bin_data = 8'hff;
    @(posedge clk); #1;
    bin_valid = 1'b0;
    wait_idle();
    chk_got("drop_report", 64'h0000_09_00000d_0002);
    chk("drop_err", 64'(err), 64'd1);

    // Output stall mid-report.
    got_q.delete();
    f = '{8'd3, 8'd7, 8'd7, 8'd0};
    send_frame(f, 1'b0);
    begin
      int n = 0;
      while (got_q.size() < 3 && n < BOUND) begin @(posedge clk); #1; n++; end
    end
    rmode = 2;
    repeat (5) @(posedge clk);
    #1 rmode = 0;
    wait_idle();
    chk_got("stall", 64'h0001_07_000011_0003);

    // Reset in the middle of a frame.
    send_beat(8'd8, 1'b0);
    send_beat(8'd9, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 64'(out_valid), 64'd0);
    got_q.delete();
    f = '{8'd1, 8'd2};
    send_frame(f, 1'b0);
    wait_idle();
    chk_got("after_reset", 64'h0001_02_000003_0002);

    // Randomized frames with random backpressure and gaps.
    rmode = 1;
    for (int k = 0; k < 25; k++) begin
      int len = $urandom_range(1, 30);
      f.delete();
      for (int i = 0; i < len; i++)
        f.push_back(($urandom_range(0, 3) == 0) ? 8'd0 :
                    ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)));
      send_frame(f, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    rmode = 0;

    // Frame longer than the index space.
    got_q.delete();
    f.delete();
    for (int i = 0; i < 513; i++) f.push_back(8'd1);
    send_frame(f, 1'b0);
    wait_idle();
    chk_got("long_frame", 64'h0000_01_000201_0201);
    chk("long_err1", 64'(err[1]), 64'd1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hist_stats
